// File: rtl/req_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the eight-way request arbiter.
// Imported by rr_pick and req_arbiter.
package req_arbiter_pkg;

   localparam int NREQ         = 8;
   localparam int IDW          = 3;
   localparam int MAX_HOLD_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   function automatic logic [NREQ-1:0] id_to_onehot(input logic [IDW-1:0] id);
      return NREQ'(1) << id;
   endfunction

endpackage

// File: rtl/req_arbiter_rr_pick.sv
// Combinational winner selection: rotate so the search start lands on bit 7,
// priority-encode with bit 7 highest, then rotate the winning index back.
module rr_pick
   import req_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] i_cand,
   input  logic            i_rr_en,
   input  logic [IDW-1:0]  i_last_id,
   output logic [IDW-1:0]  o_win_id,
   output logic            o_any
);

   logic [IDW-1:0]  w_shift;
   logic [NREQ-1:0] w_rot;
   logic [IDW-1:0]  w_rot_win;

   // Search starts at last_id-1 going down, so rotated bit j holds candidate (j+last_id) mod 8.
   assign w_shift = i_rr_en ? i_last_id : '0;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_rot
         logic [IDW-1:0] w_src;
         assign w_src     = IDW'(gi) + w_shift;
         assign w_rot[gi] = i_cand[w_src];
      end
   endgenerate

   always_comb begin
      w_rot_win = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_rot[i]) begin
            w_rot_win = IDW'(i);
         end
      end
   end

   assign o_win_id = w_rot_win + w_shift;
   assign o_any    = |i_cand;

endmodule

// File: rtl/req_arbiter.sv
// Eight-way request arbiter: one registered grant at a time, held until release,
// request drop or hold limit, with zero-bubble handover to the next requester.
module req_arbiter
   import req_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] i_req,
   input  logic            i_rr_en,
   input  logic            i_release,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_gnt_id,
   output logic            o_gnt_vld,
   output logic            o_timeout
);

   localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

   state_t          r_state;
   logic [NREQ-1:0] r_gnt;
   logic [IDW-1:0]  r_gnt_id;
   logic            r_gnt_vld;
   logic            r_timeout;
   logic [IDW-1:0]  r_last_id;
   logic [HCW-1:0]  r_hold_cnt;

   state_t          w_state_next;
   logic [NREQ-1:0] w_gnt_next;
   logic [IDW-1:0]  w_gnt_id_next;
   logic            w_gnt_vld_next;
   logic            w_timeout_next;
   logic [IDW-1:0]  w_last_id_next;
   logic [HCW-1:0]  w_hold_cnt_next;

   logic [NREQ-1:0] w_cand;
   logic [IDW-1:0]  w_win_id;
   logic            w_any;
   logic            w_req_held;
   logic            w_hold_hit;
   logic            w_end;
   logic            w_forced;

   // The current grantee is masked out so it cannot immediately win again.
   assign w_cand     = (r_state == BUSY) ? (i_req & ~r_gnt) : i_req;
   assign w_req_held = i_req[r_gnt_id];
   assign w_hold_hit = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
   assign w_end      = i_release || !w_req_held || w_hold_hit;
   assign w_forced   = w_hold_hit && !i_release && w_req_held;

   rr_pick u_rr_pick (
      .i_cand    (w_cand),
      .i_rr_en   (i_rr_en),
      .i_last_id (r_last_id),
      .o_win_id  (w_win_id),
      .o_any     (w_any)
   );

   always_comb begin
      w_state_next    = r_state;
      w_gnt_next      = r_gnt;
      w_gnt_id_next   = r_gnt_id;
      w_gnt_vld_next  = r_gnt_vld;
      w_timeout_next  = 1'b0;
      w_last_id_next  = r_last_id;
      w_hold_cnt_next = r_hold_cnt;

      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_next    = BUSY;
               w_gnt_next      = id_to_onehot(w_win_id);
               w_gnt_id_next   = w_win_id;
               w_gnt_vld_next  = 1'b1;
               w_last_id_next  = w_win_id;
               w_hold_cnt_next = '0;
            end
         end
         BUSY: begin
            if (w_end) begin
               w_timeout_next = w_forced;
               if (w_any) begin
                  w_gnt_next      = id_to_onehot(w_win_id);
                  w_gnt_id_next   = w_win_id;
                  w_last_id_next  = w_win_id;
                  w_hold_cnt_next = '0;
               end else begin
                  w_state_next   = IDLE;
                  w_gnt_next     = '0;
                  w_gnt_vld_next = 1'b0;
               end
            end else begin
               w_hold_cnt_next = r_hold_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next   = IDLE;
            w_gnt_next     = '0;
            w_gnt_vld_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_gnt_id   <= '0;
         r_gnt_vld  <= 1'b0;
         r_timeout  <= 1'b0;
         r_last_id  <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_gnt      <= w_gnt_next;
         r_gnt_id   <= w_gnt_id_next;
         r_gnt_vld  <= w_gnt_vld_next;
         r_timeout  <= w_timeout_next;
         r_last_id  <= w_last_id_next;
         r_hold_cnt <= w_hold_cnt_next;
      end
   end

   assign o_gnt     = r_gnt;
   assign o_gnt_id  = r_gnt_id;
   assign o_gnt_vld = r_gnt_vld;
   assign o_timeout = r_timeout;

endmodule

// File: tb/tb_req_arbiter.sv
// Directed-vector bench for req_arbiter with a hold limit of 4 cycles.
module tb_req_arbiter;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       rr_en;
   logic       rel;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_vld;
   logic       timeout;

   int n_cmp;
   int n_err;

   req_arbiter #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (req),
      .i_rr_en   (rr_en),
      .i_release (rel),
      .o_gnt     (gnt),
      .o_gnt_id  (gnt_id),
      .o_gnt_vld (gnt_vld),
      .o_timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] rr_seq [9];
      rr_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      req   = 8'h00;
      rr_en = 1'b0;
      rel   = 1'b0;

      #12;
      chk("rst_gnt", 32'(gnt), 32'h00);
      chk("rst_id", 32'(gnt_id), 32'd0);
      chk("rst_vld", 32'(gnt_vld), 32'd0);
      chk("rst_tmo", 32'(timeout), 32'd0);
      rst = 1'b0;

      // fixed priority: 5 beats 2
      req = 8'b0010_0100;
      step();
      chk("fp_gnt", 32'(gnt), 32'h20);
      chk("fp_id", 32'(gnt_id), 32'd5);
      chk("fp_vld", 32'(gnt_vld), 32'd1);

      req = 8'b1010_0100;
      step();
      chk("nopreempt_id", 32'(gnt_id), 32'd5);
      rel = 1'b1;
      step();
      rel = 1'b0;
      chk("handover_id", 32'(gnt_id), 32'd7);
      chk("handover_vld", 32'(gnt_vld), 32'd1);
      chk("handover_gnt", 32'(gnt), 32'h80);
      req = 8'h00;
      step();
      chk("drop_vld", 32'(gnt_vld), 32'd0);
      chk("drop_gnt", 32'(gnt), 32'h00);
      chk("drop_tmo", 32'(timeout), 32'd0);
      chk("idle_id_hold", 32'(gnt_id), 32'd7);

      // fresh reset so round-robin starts from last_id=0
      #3 rst = 1'b1;
      #2 rst = 1'b0;
      rr_en = 1'b1;
      req   = 8'hFF;
      rel   = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         chk($sformatf("rr_id_%0d", i), 32'(gnt_id), 32'(rr_seq[i]));
         chk($sformatf("rr_vld_%0d", i), 32'(gnt_vld), 32'd1);
      end
      rel = 1'b0;
      req = 8'h00;
      step();
      chk("rr_idle_vld", 32'(gnt_vld), 32'd0);

      // hold limit with a single requester: one IDLE cycle, then re-grant
      rr_en = 1'b0;
      req   = 8'h01;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("h1_vld_%0d", i), 32'(gnt_vld), 32'd1);
         chk($sformatf("h1_tmo_%0d", i), 32'(timeout), 32'd0);
      end
      step();
      chk("h1_gap_vld", 32'(gnt_vld), 32'd0);
      chk("h1_gap_tmo", 32'(timeout), 32'd1);
      step();
      chk("h1_regnt_vld", 32'(gnt_vld), 32'd1);
      chk("h1_regnt_id", 32'(gnt_id), 32'd0);
      chk("h1_regnt_tmo", 32'(timeout), 32'd0);
      req = 8'h00;
      step();
      chk("h1_end_vld", 32'(gnt_vld), 32'd0);
      chk("h1_end_tmo", 32'(timeout), 32'd0);

      // release coincident with hold limit is a normal end
      req = 8'h01;
      for (int i = 0; i < 4; i++) step();
      chk("hr_vld", 32'(gnt_vld), 32'd1);
      rel = 1'b1;
      step();
      rel = 1'b0;
      chk("hr_vld_end", 32'(gnt_vld), 32'd0);
      chk("hr_tmo", 32'(timeout), 32'd0);
      req = 8'h00;
      step();

      // hold limit with a second requester: zero-bubble handover plus timeout
      req = 8'h03;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("h2_id_%0d", i), 32'(gnt_id), 32'd1);
      end
      step();
      chk("h2_next_id", 32'(gnt_id), 32'd0);
      chk("h2_next_vld", 32'(gnt_vld), 32'd1);
      chk("h2_next_tmo", 32'(timeout), 32'd1);

      // asynchronous reset mid-grant, while timeout is still high
      #2 rst = 1'b1;
      #1;
      chk("arst_gnt", 32'(gnt), 32'h00);
      chk("arst_vld", 32'(gnt_vld), 32'd0);
      chk("arst_tmo", 32'(timeout), 32'd0);
      chk("arst_id", 32'(gnt_id), 32'd0);
      #1 rst = 1'b0;
      rr_en = 1'b1;
      req   = 8'h81;
      step();
      chk("post_rst_id", 32'(gnt_id), 32'd7);
      req = 8'h01;
      step();
      chk("post_drop_id", 32'(gnt_id), 32'd0);
      chk("post_drop_vld", 32'(gnt_vld), 32'd1);
      req = 8'h00;
      step();
      chk("final_vld", 32'(gnt_vld), 32'd0);
      chk("final_gnt", 32'(gnt), 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
